// File: rtl/pe_pkg.sv
// Shared constants, control-bit positions and the saturating adder for the
// multi-lane serial PE.
package pe_pkg;

  localparam int unsigned CTL_FIRST  = 0;
  localparam int unsigned CTL_LAST   = 1;

  // ACC_W defaults to 2*DATA_W + log2(LANES), the narrowest width that holds
  // one full lane sum at the default element width and lane count.
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_ACC_W  = 34;

  // sat_add works on values sign-extended to this width; ACC_W must stay below it.
  localparam int unsigned MAX_ACC_W  = 64;

  typedef struct packed {
    logic signed [MAX_ACC_W-1:0] sum;
    logic                        ovf;
  } sat_res_t;

  // Adds two sign-extended w-bit values. Overflow is read from the (w+1)-bit
  // result; when sat is set the sum is clamped to the w-bit signed range,
  // otherwise the caller keeps the low w bits (wrap).
  function automatic sat_res_t sat_add(input logic signed [MAX_ACC_W-1:0] a,
                                       input logic signed [MAX_ACC_W-1:0] b,
                                       input logic [5:0]                  w,
                                       input logic                        sat);
    sat_res_t                    r;
    logic signed [MAX_ACC_W-1:0] s;
    logic signed [MAX_ACC_W-1:0] lim;
    logic [5:0]                  msb;
    msb   = w - 6'd1;
    s     = a + b;
    lim   = (64'sd1 <<< msb) - 64'sd1;
    r.ovf = s[w] ^ s[msb];
    r.sum = s;
    if (r.ovf && sat) r.sum = s[w] ? ~lim : lim;
    return r;
  endfunction

endpackage

// File: rtl/vec_serial_pe_if.sv
// Beat/result bundle between the neuron/weight buffers and one PE instance.
interface vec_serial_pe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 34
);
  logic [LANES*DATA_W-1:0] neuron;
  logic [LANES*DATA_W-1:0] weight;
  logic [1:0]              ctl;
  logic                    vld_i;
  logic                    sat_en;
  logic                    relu_en;
  logic [ACC_W-1:0]        result;
  logic                    vld_o;
  logic                    ovf_o;

  modport master (
    output neuron, weight, ctl, vld_i, sat_en, relu_en,
    input  result, vld_o, ovf_o
  );

  modport slave (
    input  neuron, weight, ctl, vld_i, sat_en, relu_en,
    output result, vld_o, ovf_o
  );
endinterface

// File: rtl/pe_add_tree.sv
// Combinational signed reduction of LANES packed products into one lane sum.
module pe_add_tree #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned LANES = 4
) (
  input  logic [LANES*IN_W-1:0]                 in_flat,
  output logic signed [IN_W+$clog2(LANES)-1:0]  sum
);

  localparam int unsigned OUT_W = IN_W + $clog2(LANES);

  // Sign-extend every lane to the output width and add them up.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum = sum + OUT_W'($signed(in_flat[i*IN_W +: IN_W]));
    end
  end

endmodule

// File: rtl/vec_serial_pe.sv
// Multi-lane serial PE: per-beat LANES-wide dot product, framed accumulation
// with optional saturation and ReLU, result emitted one cycle after stage 2.
module vec_serial_pe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic          clk,
  input  logic          rst,
  vec_serial_pe_if.slave bus
);

  localparam int unsigned PW     = 2 * DATA_W;
  localparam int unsigned TREE_W = PW + $clog2(LANES);

  if (LANES < 1 || LANES > 16 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("vec_serial_pe: LANES must be a power of two in 1..16");
  end
  if (ACC_W < TREE_W || ACC_W >= MAX_ACC_W) begin : g_bad_acc_w
    $error("vec_serial_pe: ACC_W must be >= 2*DATA_W+log2(LANES) and < 64");
  end

  logic [LANES*PW-1:0]          prod;
  logic [LANES*PW-1:0]          s1_prod;
  logic                         s1_vld, s1_first, s1_last, s1_relu;
  logic signed [TREE_W-1:0]     lane_sum;
  logic signed [ACC_W-1:0]      acc_r;
  logic                         ovf_r;
  logic signed [MAX_ACC_W-1:0]  acc_base;
  sat_res_t                     add_r;
  logic signed [ACC_W-1:0]      acc_next;
  logic                         ovf_next;
  logic signed [ACC_W-1:0]      emit_next;
  logic                         em_pend;
  logic signed [ACC_W-1:0]      em_val;
  logic                         em_ovf;
  logic                         unused_sum_hi;

  // Per-lane signed products of the incoming beat.
  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[i*PW +: PW] = PW'($signed(bus.neuron[i*DATA_W +: DATA_W]))
                       * PW'($signed(bus.weight[i*DATA_W +: DATA_W]));
    end
  end

  // Stage 1: capture products and framing of each valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_prod  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
    end else begin
      s1_vld <= bus.vld_i;
      if (bus.vld_i) begin
        s1_prod  <= prod;
        s1_first <= bus.ctl[CTL_FIRST];
        s1_last  <= bus.ctl[CTL_LAST];
        s1_relu  <= bus.relu_en;
      end
    end
  end

  pe_add_tree #(.IN_W(PW), .LANES(LANES)) u_tree (
    .in_flat (s1_prod),
    .sum     (lane_sum)
  );

  // Stage 2 datapath: a FIRST beat adds onto zero, so it can never overflow
  // and its sticky flag starts clean.
  always_comb begin
    acc_base  = s1_first ? '0 : MAX_ACC_W'(acc_r);
    add_r     = sat_add(acc_base, MAX_ACC_W'(lane_sum), 6'(ACC_W), bus.sat_en);
    acc_next  = add_r.sum[ACC_W-1:0];
    ovf_next  = (s1_first ? 1'b0 : ovf_r) | add_r.ovf;
    emit_next = (s1_relu && acc_next[ACC_W-1]) ? '0 : acc_next;
  end

  assign unused_sum_hi = ^add_r.sum[MAX_ACC_W-1:ACC_W];

  // Stage 2: accumulator, sticky overflow and pending emission.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= '0;
      ovf_r   <= 1'b0;
      em_pend <= 1'b0;
      em_val  <= '0;
      em_ovf  <= 1'b0;
    end else begin
      em_pend <= s1_vld && s1_last;
      if (s1_vld) begin
        acc_r <= acc_next;
        ovf_r <= ovf_next;
        if (s1_last) begin
          em_val <= emit_next;
          em_ovf <= ovf_next;
        end
      end
    end
  end

  // Output register: result/ovf hold until the next emission.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result <= '0;
      bus.vld_o  <= 1'b0;
      bus.ovf_o  <= 1'b0;
    end else begin
      bus.vld_o <= em_pend;
      if (em_pend) begin
        bus.result <= em_val;
        bus.ovf_o  <= em_ovf;
      end
    end
  end

endmodule

// File: tb/tb_vec_serial_pe.sv
// Directed bench for vec_serial_pe with DATA_W=16, LANES=4, ACC_W=34.
module tb_vec_serial_pe;

  localparam int unsigned DW = 16;
  localparam int unsigned LN = 4;
  localparam int unsigned AW = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vec_serial_pe_if #(.DATA_W(DW), .LANES(LN), .ACC_W(AW)) bus ();

  vec_serial_pe #(.DATA_W(DW), .LANES(LN), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Present one beat; returns on the falling edge after the capturing edge.
  task automatic beat(input logic [63:0] n, input logic [63:0] w,
                      input logic [1:0] c, input logic relu);
    bus.neuron  = n;
    bus.weight  = w;
    bus.ctl     = c;
    bus.relu_en = relu;
    bus.vld_i   = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop();
    bus.vld_i = 1'b0;
    bus.ctl   = 2'b00;
  endtask

  // Falling edges until vld_o is seen, -1 if it never arrives.
  task automatic wait_vld(output int lat);
    lat = 0;
    while (bus.vld_o !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (bus.vld_o !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    bus.neuron = '0; bus.weight = '0; bus.ctl = 2'b00;
    bus.vld_i = 1'b0; bus.sat_en = 1'b0; bus.relu_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.result !== 34'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
    checks++; if (bus.vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", bus.vld_o); end
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.ovf_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Edge N captures the beat, vld_o is high after edge N+2: two falling edges
  // after the one that follows edge N.
  task automatic test_single();
    int lat;
    beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 2'b11, 1'b0);
    stop();
    wait_vld(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d exp 2", lat); end
    checks++; if (bus.result !== 34'd70) begin errors++; $display("FAIL single_result got %0d exp 70", $signed(bus.result)); end
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL single_ovf got %b exp 0", bus.ovf_o); end
    @(negedge clk);
    checks++; if (bus.vld_o !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", bus.vld_o); end
  endtask

  task automatic test_multi_beat();
    int lat;
    beat(pk(2, 2, 2, 2), pk(3, 3, 3, 3), 2'b01, 1'b0);
    beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 2'b00, 1'b0);
    beat(pk(-1, -1, -1, -1), pk(4, 4, 4, 4), 2'b10, 1'b0);
    stop();
    wait_vld(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL multi_latency got %0d exp 2", lat); end
    checks++; if (bus.result !== 34'd12) begin errors++; $display("FAIL multi_result got %0d exp 12", $signed(bus.result)); end
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL multi_ovf got %b exp 0", bus.ovf_o); end
    @(negedge clk);
  endtask

  // Each max-negative beat has lane sum 2^32; two of them exceed 2^33-1.
  task automatic test_saturation();
    int lat;
    logic [63:0] big;
    big = pk(-32768, -32768, -32768, -32768);
    bus.sat_en = 1'b1;
    beat(big, big, 2'b01, 1'b0);
    beat(big, big, 2'b10, 1'b0);
    stop();
    wait_vld(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sat_latency got %0d exp 2", lat); end
    checks++; if (bus.result !== 34'h1FFFFFFFF) begin errors++; $display("FAIL sat_result got %h exp 1ffffffff", bus.result); end
    checks++; if (bus.ovf_o !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b exp 1", bus.ovf_o); end
    @(negedge clk);
    // Held at max, then a -16 beat moves down from max.
    beat(big, big, 2'b01, 1'b0);
    beat(big, big, 2'b00, 1'b0);
    beat(pk(-1, -1, -1, -1), pk(4, 4, 4, 4), 2'b10, 1'b0);
    stop();
    wait_vld(lat);
    checks++; if (bus.result !== 34'h1FFFFFFEF) begin errors++; $display("FAIL sat_decrease got %h exp 1ffffffef", bus.result); end
    checks++; if (bus.ovf_o !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b exp 1", bus.ovf_o); end
    @(negedge clk);
    bus.sat_en = 1'b0;
    beat(big, big, 2'b01, 1'b0);
    beat(big, big, 2'b10, 1'b0);
    stop();
    wait_vld(lat);
    checks++; if (bus.result !== 34'h200000000) begin errors++; $display("FAIL wrap_result got %h exp 200000000", bus.result); end
    checks++; if (bus.ovf_o !== 1'b1) begin errors++; $display("FAIL wrap_ovf got %b exp 1", bus.ovf_o); end
    @(negedge clk);
    // A fresh FIRST beat drops the sticky flag.
    beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 2'b11, 1'b0);
    stop();
    wait_vld(lat);
    checks++; if (bus.result !== 34'd4) begin errors++; $display("FAIL first_clear_result got %0d exp 4", $signed(bus.result)); end
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL first_clear_ovf got %b exp 0", bus.ovf_o); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    beat(pk(-5, 0, 0, 0), pk(1, 0, 0, 0), 2'b11, 1'b1);
    beat(pk(3, 0, 0, 0), pk(3, 0, 0, 0), 2'b11, 1'b1);
    beat(pk(-5, 0, 0, 0), pk(1, 0, 0, 0), 2'b11, 1'b0);
    stop();
    checks++; if (bus.vld_o !== 1'b1 || bus.result !== 34'd0) begin errors++; $display("FAIL b2b_relu vld %b result %h exp 1/0", bus.vld_o, bus.result); end
    @(negedge clk);
    checks++; if (bus.vld_o !== 1'b1 || bus.result !== 34'd9) begin errors++; $display("FAIL b2b_second vld %b result %h exp 1/9", bus.vld_o, bus.result); end
    @(negedge clk);
    checks++; if (bus.vld_o !== 1'b1 || bus.result !== 34'h3FFFFFFFB) begin errors++; $display("FAIL b2b_norelu vld %b result %h exp 1/3fffffffb", bus.vld_o, bus.result); end
    @(negedge clk);
    checks++; if (bus.vld_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", bus.vld_o); end
  endtask

  task automatic test_bubbles();
    int   lat;
    logic early;
    early = 1'b0;
    beat(pk(2, 2, 2, 2), pk(3, 3, 3, 3), 2'b01, 1'b0);
    stop();
    repeat (3) begin
      @(negedge clk);
      if (bus.vld_o !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL bubble_early got %b exp 0", early); end
    beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 2'b10, 1'b0);
    stop();
    wait_vld(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL bubble_latency got %0d exp 2", lat); end
    checks++; if (bus.result !== 34'd28) begin errors++; $display("FAIL bubble_result got %0d exp 28", $signed(bus.result)); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sum();
    int   lat;
    logic seen;
    seen = 1'b0;
    beat(pk(2, 2, 2, 2), pk(3, 3, 3, 3), 2'b01, 1'b0);
    beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 2'b10, 1'b0);
    stop();
    rst = 1'b1;
    #1;
    checks++; if (bus.result !== 34'h0) begin errors++; $display("FAIL midrst_result got %h exp 0", bus.result); end
    checks++; if (bus.vld_o !== 1'b0) begin errors++; $display("FAIL midrst_vld got %b exp 0", bus.vld_o); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.vld_o !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_dropped got %b exp 0", seen); end
    beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 2'b11, 1'b0);
    stop();
    wait_vld(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL midrst_latency got %0d exp 2", lat); end
    checks++; if (bus.result !== 34'd4) begin errors++; $display("FAIL midrst_new_sum got %0d exp 4", $signed(bus.result)); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_beat();
    test_saturation();
    test_back_to_back();
    test_bubbles();
    test_reset_mid_sum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
